// File: rtl/mult8x8_acc_if.sv
// Handshake bundle for the 8x8-multiplier product accumulator: job start,
// product stream in, result stream out.
interface mult8x8_acc_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) ();
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      R;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] SUM;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, len, R, in_valid, out_ready,
    input  in_ready, SUM, ovf, out_valid, busy
  );

  modport slave (
    input  start, len, R, in_valid, out_ready,
    output in_ready, SUM, ovf, out_valid, busy
  );
endinterface

// File: rtl/mult8x8_acc.sv
// Saturating accumulator of len unsigned 16-bit products per job, with
// valid/ready product input and a held result until the consumer accepts it.
module mult8x8_acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input logic          clk,
  input logic          rst,
  mult8x8_acc_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [ACC_W:0]   acc_sum_c;
  logic             xfer_c;
  logic             last_c;

  // Next-state and datapath; outputs are decoded from the next state so they
  // are registered alongside it.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;

    acc_sum_c   = {1'b0, acc_q} + (ACC_W + 1)'(bus.R);
    xfer_c      = bus.in_valid && in_ready_q;
    last_c      = (cnt_q + LEN_W'(1)) == len_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          len_d = bus.len;
          if (bus.len != '0) begin
            state_d = S_ACC;
          end else begin
            sum_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ACC: begin
        if (xfer_c) begin
          // A carry out of the top bit means the true sum no longer fits.
          if (acc_sum_c[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_sum_c[ACC_W-1:0];
          end
          cnt_d = cnt_q + LEN_W'(1);
          if (last_c) begin
            sum_d   = acc_d;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_ACC);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.SUM       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult8x8_acc.sv
// Bench for mult8x8_acc: directed scenarios plus random handshake jobs,
// results checked against a reference-sum scoreboard.
module tb_mult8x8_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult8x8_acc_if #(.ACC_W(24), .LEN_W(8)) b0 ();
  mult8x8_acc_if #(.ACC_W(17), .LEN_W(8)) b1 ();

  mult8x8_acc #(.ACC_W(24), .LEN_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mult8x8_acc #(.ACC_W(17), .LEN_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    longint sum;
    bit     ovf;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp0_q[$];
  exp_t        exp1_q[$];
  exp_t        e0, e1;
  logic [15:0] stim[$];
  int          rdy_mode = 0;  // 0: task drives, 1: held high, 2: random
  logic        prev_v0;
  logic [23:0] prev_sum0;

  localparam longint MAX24 = (longint'(1) << 24) - 1;
  localparam longint MAX17 = (longint'(1) << 17) - 1;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int n, input longint maxv);
    exp_t e;
    e.sum = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.sum += longint'(stim[i]);
      if (e.sum > maxv) begin
        e.sum = maxv;
        e.ovf = 1'b1;
      end
    end
    return e;
  endfunction

  // Background out_ready driver for the 24-bit instance.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 1) b0.out_ready = 1'b1;
      else if (rdy_mode == 2) b0.out_ready = 1'($urandom_range(1));
    end
  end

  // Scoreboard and protocol monitor, 24-bit instance.
  always @(negedge clk) begin
    if (rst) begin
      prev_v0 <= 1'b0;
    end else begin
      if (b0.out_valid && prev_v0) begin
        checks++;
        if (b0.SUM !== prev_sum0) begin
          errors++;
          $display("FAIL sum_stable0 got %0d want %0d", b0.SUM, prev_sum0);
        end
      end
      prev_v0   <= b0.out_valid;
      prev_sum0 <= b0.SUM;
      if (b0.out_valid && b0.out_ready) begin
        checks++;
        if (exp0_q.size() == 0) begin
          errors++;
          $display("FAIL result0_unexpected got SUM=%0d want no result", b0.SUM);
        end else begin
          e0 = exp0_q.pop_front();
          if (b0.SUM !== 24'(e0.sum) || b0.ovf !== e0.ovf) begin
            errors++;
            $display("FAIL result0 got SUM=%0d ovf=%0b want SUM=%0d ovf=%0b",
                     b0.SUM, b0.ovf, e0.sum, e0.ovf);
          end
        end
      end
      if (b0.in_ready) begin
        checks++;
        if (!b0.busy || b0.out_valid) begin
          errors++;
          $display("FAIL in_ready_outside_acc got busy=%0b out_valid=%0b want busy=1 out_valid=0",
                   b0.busy, b0.out_valid);
        end
      end
    end
  end

  // Scoreboard, 17-bit instance.
  always @(negedge clk) begin
    if (!rst && b1.out_valid && b1.out_ready) begin
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL result1_unexpected got SUM=%0h want no result", b1.SUM);
      end else begin
        e1 = exp1_q.pop_front();
        if (b1.SUM !== 17'(e1.sum) || b1.ovf !== e1.ovf) begin
          errors++;
          $display("FAIL result1 got SUM=%0h ovf=%0b want SUM=%0h ovf=%0b",
                   b1.SUM, b1.ovf, e1.sum, e1.ovf);
        end
      end
    end
  end

  // One job on the 24-bit instance using stim[0..lenv-1]; pv is the in_valid
  // percentage. Random start pulses during the job must be ignored.
  task automatic run_job(input int lenv, input int pv, input bit wait_done);
    int idx;
    int cyc;
    bit will;
    exp0_q.push_back(model(lenv, MAX24));
    b0.start = 1'b1;
    b0.len   = 8'(lenv);
    step();
    b0.start = 1'b0;
    checks++;
    if (b0.busy !== 1'b1) begin
      errors++;
      $display("FAIL job_start got busy=%0b want 1", b0.busy);
    end
    idx = 0;
    cyc = 0;
    while (idx < lenv && cyc < 20 * lenv + 100) begin
      b0.in_valid = ($urandom_range(99) < pv);
      b0.R        = b0.in_valid ? stim[idx] : 16'($urandom);
      b0.start    = ($urandom_range(7) == 0);
      b0.len      = 8'($urandom);
      will        = b0.in_valid && b0.in_ready;
      step();
      cyc++;
      if (will) idx++;
    end
    b0.in_valid = 1'b0;
    b0.start    = 1'b0;
    checks++;
    if (idx < lenv) begin
      errors++;
      $display("FAIL job_accept_timeout got %0d products want %0d", idx, lenv);
    end else if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_latency got out_valid=%0b in_ready=%0b want 1 0",
               b0.out_valid, b0.in_ready);
    end
    if (wait_done) begin
      cyc = 0;
      while (b0.busy && cyc < 2000) begin
        b0.in_valid = 1'($urandom_range(1));
        b0.R        = 16'($urandom);
        b0.start    = 1'($urandom_range(1));
        b0.len      = 8'($urandom);
        step();
        cyc++;
      end
      b0.in_valid = 1'b0;
      b0.start    = 1'b0;
      checks++;
      if (b0.busy !== 1'b0) begin
        errors++;
        $display("FAIL job_done_timeout got busy=%0b want 0", b0.busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({b0.in_ready, b0.out_valid, b0.busy, b0.ovf, b0.SUM} !== '0) begin
      errors++;
      $display("FAIL reset0 got in_ready=%0b out_valid=%0b busy=%0b ovf=%0b SUM=%0d want all 0",
               b0.in_ready, b0.out_valid, b0.busy, b0.ovf, b0.SUM);
    end
    checks++;
    if ({b1.in_ready, b1.out_valid, b1.busy, b1.ovf, b1.SUM} !== '0) begin
      errors++;
      $display("FAIL reset1 got in_ready=%0b out_valid=%0b busy=%0b ovf=%0b SUM=%0d want all 0",
               b1.in_ready, b1.out_valid, b1.busy, b1.ovf, b1.SUM);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic;
    rdy_mode     = 0;
    b0.out_ready = 1'b0;
    stim = '{16'd100, 16'd200, 16'd300, 16'd400};
    run_job(4, 100, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.SUM !== 24'd1000 || b0.ovf !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold got out_valid=%0b SUM=%0d ovf=%0b want 1 1000 0",
                 b0.out_valid, b0.SUM, b0.ovf);
      end
    end
    // start coinciding with acceptance must be dropped
    b0.out_ready = 1'b1;
    b0.start     = 1'b1;
    b0.len       = 8'd5;
    step();
    b0.start     = 1'b0;
    b0.out_ready = 1'b0;
    checks++;
    if (b0.busy !== 1'b0 || b0.out_valid !== 1'b0 || b0.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_at_accept got busy=%0b out_valid=%0b in_ready=%0b want 0 0 0",
               b0.busy, b0.out_valid, b0.in_ready);
    end
    step();
    checks++;
    if (b0.busy !== 1'b0 || b0.SUM !== 24'd1000) begin
      errors++;
      $display("FAIL idle_hold got busy=%0b SUM=%0d want 0 1000", b0.busy, b0.SUM);
    end
  endtask

  task automatic test_bubbles;
    rdy_mode = 1;
    stim = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    exp0_q.push_back(model(3, MAX24));
    b0.start = 1'b1;
    b0.len   = 8'd3;
    step();
    b0.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b0.in_valid = 1'b1;
      b0.R        = 16'hFFFF;
      step();
      b0.in_valid = 1'b0;
      if (k < 2) begin
        for (int b = 0; b < 3; b++) begin
          checks++;
          if (b0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bubble_ready got in_ready=%0b want 1", b0.in_ready);
          end
          if (b < 2) begin
            b0.R = 16'($urandom);
            step();
          end
        end
      end
    end
    checks++;
    if (b0.out_valid !== 1'b1 || b0.SUM !== 24'd196605) begin
      errors++;
      $display("FAIL bubble_sum got out_valid=%0b SUM=%0d want 1 196605", b0.out_valid, b0.SUM);
    end
    step();
    checks++;
    if (b0.out_valid !== 1'b0 || b0.busy !== 1'b0) begin
      errors++;
      $display("FAIL early_ready got out_valid=%0b busy=%0b want 0 0", b0.out_valid, b0.busy);
    end
  endtask

  task automatic test_len_zero;
    rdy_mode     = 0;
    b0.out_ready = 1'b0;
    stim.delete();
    exp0_q.push_back(model(0, MAX24));
    b0.start = 1'b1;
    b0.len   = 8'd0;
    step();
    b0.start = 1'b0;
    checks++;
    if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0 || b0.SUM !== 24'd0) begin
      errors++;
      $display("FAIL len0_done got out_valid=%0b in_ready=%0b SUM=%0d want 1 0 0",
               b0.out_valid, b0.in_ready, b0.SUM);
    end
    for (int k = 0; k < 5; k++) begin
      b0.start    = 1'b1;
      b0.len      = 8'($urandom_range(255, 1));
      b0.in_valid = 1'b1;
      step();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.busy !== 1'b1 || b0.in_ready !== 1'b0 || b0.SUM !== 24'd0) begin
        errors++;
        $display("FAIL len0_stall got out_valid=%0b busy=%0b in_ready=%0b SUM=%0d want 1 1 0 0",
                 b0.out_valid, b0.busy, b0.in_ready, b0.SUM);
      end
    end
    b0.start     = 1'b0;
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    step();
    b0.out_ready = 1'b0;
    checks++;
    if (b0.busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_release got busy=%0b want 0", b0.busy);
    end
  endtask

  task automatic test_sat17;
    b1.out_ready = 1'b1;
    stim = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    exp1_q.push_back(model(3, MAX17));
    b1.start = 1'b1;
    b1.len   = 8'd3;
    step();
    b1.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b1.in_valid = 1'b1;
      b1.R        = 16'hFFFF;
      step();
    end
    b1.in_valid = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b1 || b1.SUM !== 17'h1FFFF || b1.ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat17 got out_valid=%0b SUM=%0h ovf=%0b want 1 1ffff 1",
               b1.out_valid, b1.SUM, b1.ovf);
    end
    step();
    stim = '{16'd5};
    exp1_q.push_back(model(1, MAX17));
    b1.start = 1'b1;
    b1.len   = 8'd1;
    step();
    b1.start = 1'b0;
    checks++;
    if (b1.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%0b want 0", b1.ovf);
    end
    b1.in_valid = 1'b1;
    b1.R        = 16'd5;
    step();
    b1.in_valid = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b1 || b1.SUM !== 17'd5 || b1.ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_sat got out_valid=%0b SUM=%0d ovf=%0b want 1 5 0",
               b1.out_valid, b1.SUM, b1.ovf);
    end
    step();
  endtask

  task automatic test_reset_mid;
    rdy_mode = 1;
    b0.start = 1'b1;
    b0.len   = 8'd4;
    step();
    b0.start = 1'b0;
    b0.in_valid = 1'b1;
    b0.R = 16'd11;
    step();
    b0.R = 16'd22;
    step();
    b0.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({b0.in_ready, b0.out_valid, b0.busy, b0.ovf, b0.SUM} !== '0) begin
      errors++;
      $display("FAIL reset_mid got in_ready=%0b out_valid=%0b busy=%0b ovf=%0b SUM=%0d want all 0",
               b0.in_ready, b0.out_valid, b0.busy, b0.ovf, b0.SUM);
    end
    step();
    rst = 1'b0;
    stim = '{16'd7, 16'd9};
    run_job(2, 100, 1'b1);
  endtask

  task automatic test_max_len;
    rdy_mode = 2;
    stim.delete();
    for (int i = 0; i < 255; i++) stim.push_back(16'($urandom));
    run_job(255, 75, 1'b1);
  endtask

  task automatic test_random;
    int n;
    rdy_mode = 2;
    for (int j = 0; j < 1000; j++) begin
      n = $urandom_range(12);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
      run_job(n, 50, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    b0.start = 1'b0; b0.len = '0; b0.R = '0; b0.in_valid = 1'b0; b0.out_ready = 1'b0;
    b1.start = 1'b0; b1.len = '0; b1.R = '0; b1.in_valid = 1'b0; b1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_len_zero();
    test_sat17();
    test_reset_mid();
    test_max_len();
    test_random();
    step();
    checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending want 0/0", exp0_q.size(), exp1_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult8x8_acc.md
MULT8X8_ACC -- requirements
Module: mult8x8_acc

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, giving the accumulator and SUM width (legal range 17..32).
REQ-002 The block SHALL have parameter LEN_W, default 8, giving the width of the product-count field.
REQ-003 Port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: begins a new accumulation, sampled only in IDLE.
REQ-006 Port len, input, LEN_W bits: number of products to accumulate, sampled with start.
REQ-007 Port R, input, 16 bits: unsigned product from the 8x8 approximate multiplier.
REQ-008 Port in_valid, input, 1 bit: R holds a valid product.
REQ-009 Port in_ready, output, 1 bit: the block accepts a product this cycle.
REQ-010 Port SUM, output, ACC_W bits: the accumulated result.
REQ-011 Port ovf, output, 1 bit: the result saturated.
REQ-012 Port out_valid, output, 1 bit: SUM and ovf are valid.
REQ-013 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-016 In IDLE with start=1 and len!=0, the block SHALL clear acc and cnt, clear ovf, latch len, and enter ACC on the next cycle.
REQ-017 In IDLE with start=1 and len=0, the block SHALL clear acc and ovf and enter DONE directly, producing SUM=0.
REQ-018 The block SHALL ignore start in ACC and DONE, with no effect on state, counters or latched len.
REQ-019 in_ready SHALL be a registered-state decode, high only in ACC and never combinationally dependent on in_valid.
REQ-020 A transfer SHALL occur exactly when in_valid=1 and in_ready=1 in the same cycle, and the block SHALL not accept a product otherwise.
REQ-021 On each transfer, acc SHALL become acc + zero-extended R, and cnt SHALL increment by 1.
REQ-022 If acc + R exceeds 2^ACC_W-1, acc SHALL saturate to all-ones and ovf SHALL set and stay set until the next start.
REQ-023 Once saturated, acc SHALL remain all-ones for the rest of the job.
REQ-024 On the transfer that makes cnt equal to the latched len, the block SHALL enter DONE on the next cycle, and in_ready SHALL be low from that cycle on.
REQ-025 SUM, ovf and out_valid SHALL be registered, and out_valid SHALL rise in the first DONE cycle, so the latency is 1 cycle from the last transfer to out_valid.
REQ-026 In DONE, out_valid SHALL be 1 and SUM and ovf SHALL hold stable until out_ready=1.
REQ-027 In DONE with out_ready=1, the block SHALL drop out_valid and return to IDLE on the next cycle.
REQ-028 A start asserted in the same cycle as the out_ready acceptance SHALL be ignored, because the block is not yet in IDLE.
REQ-029 In_valid gaps (bubbles) in ACC SHALL stall accumulation with no state change, and the block SHALL have no timeout.
REQ-030 A len of 2^LEN_W-1 SHALL be supported, and cnt SHALL be LEN_W bits wide with no wrap before the terminal compare.
REQ-031 In IDLE, SUM and ovf SHALL hold the last delivered result, and out_valid SHALL be 0.
REQ-032 The block SHALL accept out_ready=1 asserted before out_valid and act on it in the first DONE cycle, giving a 1-cycle DONE.

Reset
REQ-033 While rst=1, the block SHALL asynchronously force state=IDLE, acc=0, cnt=0, latched len=0, SUM=0, ovf=0, out_valid=0, in_ready=0 and busy=0.
REQ-034 A reset asserted mid-ACC or mid-DONE SHALL abandon the job with no output pulse, and the first post-reset cycle SHALL accept start.
REQ-035 Reset release SHALL be usable synchronous to clk, and the block SHALL require no state other than the FSM to be initialised.

Verification
REQ-036 Directed test: start with len=4, then R=100, 200, 300, 400 on consecutive cycles -> out_valid 1 cycle after the 4th transfer, SUM=1000, ovf=0.
REQ-037 Directed test: len=3 with in_valid bubbles of 2 cycles between products R=0xFFFF each -> SUM=196605, and in_ready stays high throughout ACC.
REQ-038 Directed test: ACC_W=17, len=3, R=0xFFFF x3 -> SUM=0x1FFFF, ovf=1; then start with len=1 and R=5 -> SUM=5, ovf=0.
REQ-039 Directed test: start with len=0 -> DONE next cycle, SUM=0, no in_ready pulse; out_ready held low for 5 cycles -> SUM stable, and start pulses are ignored.
REQ-040 Directed test: reset asserted after 2 of 4 products -> all outputs 0 immediately; then start with len=2 and R=7, 9 -> SUM=16.
REQ-041 Directed test: random in_valid/out_ready (50%) over 1000 jobs against a reference sum model -> every SUM and ovf matches, and there are no transfers outside ACC.
